// File: rtl/cvw.sv
// Shared definitions for the Writeback-stage register-file write arbiter.
package cvw;
    localparam int RA_W = 5;

    typedef logic [0:0] wbarb_state_t;
    localparam wbarb_state_t IDLE  = 1'b0;
    localparam wbarb_state_t DRAIN = 1'b1;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bundle / register-file write-port bus of the arbiter.
// Lookup ports exist only when WBARB_BYPASS_EN is defined.
interface regfile_wb_arbiter_if
    import cvw::*;
#(
    parameter int XLEN   = 64,
    parameter int LANES  = 4,
    parameter int WPORTS = 2
);
    logic                     BundleValidW;
    logic [LANES-1:0]         RegWriteW;
    logic [LANES*RA_W-1:0]    RdW;
    logic [LANES*XLEN-1:0]    ResultW;
    logic                     FlushW;
    logic                     BundleReadyW;
    logic                     WBArbStallW;
    logic [WPORTS-1:0]        we3;
    logic [WPORTS*RA_W-1:0]   a3;
    logic [WPORTS*XLEN-1:0]   wd3;
`ifdef WBARB_BYPASS_EN
    logic [2*RA_W-1:0]        ByRs;
    logic [1:0]               ByHit;
    logic [2*XLEN-1:0]        ByData;
`endif

    modport master (
        output BundleValidW, RegWriteW, RdW, ResultW, FlushW,
`ifdef WBARB_BYPASS_EN
        output ByRs,
        input  ByHit, ByData,
`endif
        input  BundleReadyW, WBArbStallW, we3, a3, wd3
    );

    modport slave (
        input  BundleValidW, RegWriteW, RdW, ResultW, FlushW,
`ifdef WBARB_BYPASS_EN
        input  ByRs,
        output ByHit, ByData,
`endif
        output BundleReadyW, WBArbStallW, we3, a3, wd3
    );
endinterface

// File: rtl/wbarb_pick.sv
// Selects the lowest WPORTS set bits of a request mask as one-hot grants per port;
// 'more' flags requests left over after all ports are granted.
module wbarb_pick #(
    parameter int LANES  = 4,
    parameter int WPORTS = 2
) (
    input  logic [LANES-1:0]             req,
    output logic [WPORTS-1:0][LANES-1:0] grant,
    output logic [LANES-1:0]             grant_any,
    output logic                         more
);
    logic [LANES-1:0] rem;

    always_comb begin
        rem       = req;
        grant     = '0;
        grant_any = '0;
        for (int k = 0; k < WPORTS; k++) begin
            // Two's-complement trick isolates the lowest remaining set bit.
            grant[k]  = rem & (~rem + LANES'(1));
            grant_any = grant_any | grant[k];
            rem       = rem & ~grant[k];
        end
        more = |rem;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Captures a Writeback bundle, squashes x0 and overridden same-rd writes, and drains
// the rest over WPORTS register-file write ports. WBARB_BYPASS_EN adds pending-write lookup.
module regfile_wb_arbiter
    import cvw::*;
#(
    parameter int XLEN   = 64,
    parameter int LANES  = 4,
    parameter int WPORTS = 2
) (
    input logic                clk,
    input logic                reset,
    regfile_wb_arbiter_if.slave bus
);
    wbarb_state_t                 state;
    logic [LANES-1:0]             pend_p1;
    logic [LANES-1:0][RA_W-1:0]   rd_p1;
    logic [LANES-1:0][XLEN-1:0]   data_p1;

    logic [LANES-1:0][RA_W-1:0]   rd_in;
    logic [LANES-1:0]             eff;
    logic [WPORTS-1:0][LANES-1:0] grant;
    logic [LANES-1:0]             grant_any;
    logic [LANES-1:0]             pend_next;
    logic                         more;
    logic                         drain;
    logic                         capture;

    assign rd_in = bus.RdW;

    // A lane survives only if it writes a nonzero rd that no younger lane overwrites.
    always_comb begin
        eff = '0;
        for (int i = 0; i < LANES; i++) begin
            eff[i] = bus.RegWriteW[i] && (rd_in[i] != '0);
            for (int j = i + 1; j < LANES; j++) begin
                if (bus.RegWriteW[j] && (rd_in[j] == rd_in[i]))
                    eff[i] = 1'b0;
            end
        end
    end

    wbarb_pick #(
        .LANES (LANES),
        .WPORTS(WPORTS)
    ) u_pick (
        .req      (pend_p1),
        .grant    (grant),
        .grant_any(grant_any),
        .more     (more)
    );

    assign drain            = (state == DRAIN);
    assign pend_next        = pend_p1 & ~grant_any;
    assign bus.BundleReadyW = !drain || !more;
    assign bus.WBArbStallW  = drain && more;
    assign capture          = bus.BundleValidW && bus.BundleReadyW && !bus.FlushW;

    always_comb begin
        bus.we3 = '0;
        bus.a3  = '0;
        bus.wd3 = '0;
        for (int k = 0; k < WPORTS; k++) begin
            for (int i = 0; i < LANES; i++) begin
                if (drain && grant[k][i]) begin
                    bus.we3[k]                 = 1'b1;
                    bus.a3[RA_W*k +: RA_W]     = rd_p1[i];
                    bus.wd3[XLEN*k +: XLEN]    = data_p1[i];
                end
            end
        end
    end

    // Control: a capture while draining only happens once the final group is issuing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pend_p1 <= '0;
        end else if (bus.FlushW) begin
            state   <= IDLE;
            pend_p1 <= '0;
        end else if (capture) begin
            state   <= (|eff) ? DRAIN : IDLE;
            pend_p1 <= eff;
        end else if (drain) begin
            pend_p1 <= pend_next;
            if (pend_next == '0)
                state <= IDLE;
        end
    end

    // Held data is only observed through pend_p1, so it carries no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            rd_p1   <= rd_in;
            data_p1 <= bus.ResultW;
        end
    end

`ifdef WBARB_BYPASS_EN
    logic [RA_W-1:0] by_rs;

    always_comb begin
        bus.ByHit  = '0;
        bus.ByData = '0;
        by_rs      = '0;
        for (int n = 0; n < 2; n++) begin
            by_rs = bus.ByRs[RA_W*n +: RA_W];
            for (int i = 0; i < LANES; i++) begin
                if (pend_p1[i] && (by_rs != '0) && (rd_p1[i] == by_rs)) begin
                    bus.ByHit[n]                = 1'b1;
                    bus.ByData[XLEN*n +: XLEN]  = data_p1[i];
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (LANES=4, WPORTS=2, XLEN=64).
module tb_regfile_wb_arbiter;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    localparam logic [63:0] L0 = 64'h1000_0000_0000_00a0;
    localparam logic [63:0] L1 = 64'h2000_0000_0000_00a1;
    localparam logic [63:0] L2 = 64'h3000_0000_0000_00a2;
    localparam logic [63:0] L3 = 64'h4000_0000_0000_00a3;
    localparam logic [63:0] B0 = 64'h5555_0000_0000_00b0;
    localparam logic [63:0] B1 = 64'h6666_0000_0000_00b1;
    localparam logic [63:0] B2 = 64'h7777_0000_0000_00b2;
    localparam logic [63:0] DEAD = 64'h0000_0000_0000_dead;

    regfile_wb_arbiter_if #(.XLEN(64), .LANES(4), .WPORTS(2)) bus ();

    regfile_wb_arbiter #(.XLEN(64), .LANES(4), .WPORTS(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [3:0] we, input logic [19:0] rd, input logic [255:0] res);
        bus.BundleValidW = 1'b1;
        bus.RegWriteW    = we;
        bus.RdW          = rd;
        bus.ResultW      = res;
    endtask

    task automatic idle_in();
        bus.BundleValidW = 1'b0;
        bus.RegWriteW    = '0;
    endtask

    task automatic test_reset();
        logic [139:0] got, exp;
        reset = 1'b1;
        idle_in();
        bus.FlushW = 1'b0;
        bus.RdW = '0;
        bus.ResultW = '0;
`ifdef WBARB_BYPASS_EN
        bus.ByRs = '0;
`endif
        step();
        step();
        reset = 1'b0;
        step();
        got = {bus.we3, bus.a3, bus.wd3};
        exp = '0;
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_ports: got %h want %h", got, exp);
        end
        n_checks++;
        if ({bus.WBArbStallW, bus.BundleReadyW} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 01", {bus.WBArbStallW, bus.BundleReadyW});
        end
    endtask

    task automatic test_four_writes();
        logic [139:0] got, exp;
        present(4'hf, {5'd4, 5'd3, 5'd2, 5'd1}, {L3, L2, L1, L0});
        n_checks++;
        if (bus.BundleReadyW !== 1'b1) begin
            n_fail++;
            $display("FAIL four_ready_idle: got %b want 1", bus.BundleReadyW);
        end
        step();
        idle_in();
        got = {bus.we3, bus.a3, bus.wd3};
        exp = {2'b11, 5'd2, 5'd1, L1, L0};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL four_c1_ports: got %h want %h", got, exp);
        end
        n_checks++;
        if ({bus.WBArbStallW, bus.BundleReadyW} !== 2'b10) begin
            n_fail++;
            $display("FAIL four_c1_ctrl: got %b want 10", {bus.WBArbStallW, bus.BundleReadyW});
        end
        step();
        got = {bus.we3, bus.a3, bus.wd3};
        exp = {2'b11, 5'd4, 5'd3, L3, L2};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL four_c2_ports: got %h want %h", got, exp);
        end
        n_checks++;
        if ({bus.WBArbStallW, bus.BundleReadyW} !== 2'b01) begin
            n_fail++;
            $display("FAIL four_c2_ctrl: got %b want 01", {bus.WBArbStallW, bus.BundleReadyW});
        end
        step();
        n_checks++;
        if (bus.we3 !== 2'b00) begin
            n_fail++;
            $display("FAIL four_c3_idle: got %b want 00", bus.we3);
        end
    endtask

    task automatic test_squash();
        logic [139:0] got, exp;
        present(4'hf, {5'd7, 5'd0, 5'd5, 5'd5}, {L3, L2, L1, L0});
        step();
        idle_in();
        got = {bus.we3, bus.a3, bus.wd3};
        exp = {2'b11, 5'd7, 5'd5, L3, L1};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL squash_ports: got %h want %h", got, exp);
        end
        n_checks++;
        if ({bus.WBArbStallW, bus.BundleReadyW} !== 2'b01) begin
            n_fail++;
            $display("FAIL squash_ctrl: got %b want 01", {bus.WBArbStallW, bus.BundleReadyW});
        end
        step();
        n_checks++;
        if (bus.we3 !== 2'b00) begin
            n_fail++;
            $display("FAIL squash_done: got %b want 00", bus.we3);
        end
    endtask

    task automatic test_x0_only();
        present(4'b0011, {5'd9, 5'd8, 5'd0, 5'd0}, {L3, L2, L1, L0});
        step();
        idle_in();
        n_checks++;
        if ({bus.we3, bus.WBArbStallW, bus.BundleReadyW} !== 4'b0001) begin
            n_fail++;
            $display("FAIL x0_only: got %b want 0001", {bus.we3, bus.WBArbStallW, bus.BundleReadyW});
        end
    endtask

    task automatic test_back_to_back();
        logic [139:0] got, exp;
        present(4'b0111, {5'd0, 5'd3, 5'd2, 5'd1}, {64'h0, L2, L1, L0});
        step();
        present(4'b0111, {5'd0, 5'd10, 5'd9, 5'd8}, {64'h0, B2, B1, B0});
        got = {bus.we3, bus.a3, bus.wd3};
        exp = {2'b11, 5'd2, 5'd1, L1, L0};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL b2b_c1_ports: got %h want %h", got, exp);
        end
        n_checks++;
        if ({bus.WBArbStallW, bus.BundleReadyW} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_c1_ctrl: got %b want 10", {bus.WBArbStallW, bus.BundleReadyW});
        end
        step();
        got = {bus.we3, bus.a3, bus.wd3};
        exp = {2'b01, 5'd0, 5'd3, 64'h0, L2};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL b2b_c2_ports: got %h want %h", got, exp);
        end
        n_checks++;
        if ({bus.WBArbStallW, bus.BundleReadyW} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_c2_ctrl: got %b want 01", {bus.WBArbStallW, bus.BundleReadyW});
        end
        step();
        idle_in();
        got = {bus.we3, bus.a3, bus.wd3};
        exp = {2'b11, 5'd9, 5'd8, B1, B0};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL b2b_c3_ports: got %h want %h", got, exp);
        end
        n_checks++;
        if (bus.WBArbStallW !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_c3_stall: got %b want 1", bus.WBArbStallW);
        end
        step();
        got = {bus.we3, bus.a3, bus.wd3};
        exp = {2'b01, 5'd0, 5'd10, 64'h0, B2};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL b2b_c4_ports: got %h want %h", got, exp);
        end
        step();
        n_checks++;
        if ({bus.we3, bus.WBArbStallW} !== 3'b000) begin
            n_fail++;
            $display("FAIL b2b_c5_idle: got %b want 000", {bus.we3, bus.WBArbStallW});
        end
    endtask

    task automatic test_flush();
        logic [139:0] got, exp;
        present(4'hf, {5'd4, 5'd3, 5'd2, 5'd1}, {L3, L2, L1, L0});
        step();
        idle_in();
        bus.FlushW = 1'b1;
        got = {bus.we3, bus.a3, bus.wd3};
        exp = {2'b11, 5'd2, 5'd1, L1, L0};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL flush_c1_ports: got %h want %h", got, exp);
        end
        step();
        bus.FlushW = 1'b0;
        n_checks++;
        if ({bus.we3, bus.WBArbStallW, bus.BundleReadyW} !== 4'b0001) begin
            n_fail++;
            $display("FAIL flush_c2: got %b want 0001", {bus.we3, bus.WBArbStallW, bus.BundleReadyW});
        end
        step();
        n_checks++;
        if (bus.we3 !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_c3: got %b want 00", bus.we3);
        end
    endtask

    task automatic test_reset_mid_drain();
        present(4'hf, {5'd4, 5'd3, 5'd2, 5'd1}, {L3, L2, L1, L0});
        step();
        idle_in();
        n_checks++;
        if (bus.we3 !== 2'b11) begin
            n_fail++;
            $display("FAIL rst_mid_c1: got %b want 11", bus.we3);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if ({bus.we3, bus.WBArbStallW, bus.BundleReadyW} !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_mid_c2: got %b want 0001", {bus.we3, bus.WBArbStallW, bus.BundleReadyW});
        end
        step();
        n_checks++;
        if (bus.we3 !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_mid_c3: got %b want 00", bus.we3);
        end
    endtask

`ifdef WBARB_BYPASS_EN
    task automatic test_bypass();
        logic [129:0] got, exp;
        present(4'hf, {5'd4, 5'd3, 5'd2, 5'd1}, {DEAD, L2, L1, L0});
        step();
        idle_in();
        bus.ByRs = {5'd1, 5'd4};
        #1;
        got = {bus.ByHit, bus.ByData};
        exp = {2'b11, L0, DEAD};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL byp_c1: got %h want %h", got, exp);
        end
        step();
        bus.ByRs = {5'd0, 5'd4};
        #1;
        got = {bus.ByHit, bus.ByData};
        exp = {2'b01, 64'h0, DEAD};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL byp_c2: got %h want %h", got, exp);
        end
        step();
        n_checks++;
        if (bus.ByHit !== 2'b00) begin
            n_fail++;
            $display("FAIL byp_c3: got %b want 00", bus.ByHit);
        end
        bus.ByRs = '0;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_four_writes();
        test_squash();
        test_x0_only();
        test_back_to_back();
        test_flush();
        test_reset_mid_drain();
`ifdef WBARB_BYPASS_EN
        test_bypass();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
